// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter joining a fetch port and a data port onto a 16-bit async SRAM,
// moving each big-endian 32-bit word as two halfword cycles (HI then LO).
module mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [17:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [17:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic [17:0] addr,
  inout  wire  [15:0] data,
  output logic        wre,
  output logic        oute,
  output logic        chip_en,
  output logic        hb_mask,
  output logic        lb_mask
);
  typedef enum logic [1:0] {IDLE, HI, LO, ACK} state_t;
  state_t      state, state_nx;
  logic        grant, pick_dm, act, wr;
  logic        cur_dm, last_dm, we_q;
  logic [17:0] gaddr;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [15:0] hi_q;
  always_comb begin
    grant    = (state == IDLE || state == ACK) && (if_req || dm_req);
    pick_dm  = dm_req && (!if_req || !last_dm);
    gaddr    = (pick_dm ? dm_addr : if_addr) & ~18'd1;
    state_nx = state == HI ? LO : state == LO ? ACK : grant ? HI : IDLE;
    act      = state == HI || state == LO;
    wr       = act && we_q;
    chip_en  = !act;
    oute     = !(act && !we_q);
    wre      = !wr;
    hb_mask  = !act ? 1'b1 : we_q ? ~(state == HI ? be_q[3] : be_q[1]) : 1'b0;
    lb_mask  = !act ? 1'b1 : we_q ? ~(state == HI ? be_q[2] : be_q[0]) : 1'b0;
    if_ack   = state == ACK && !cur_dm;
    dm_ack   = state == ACK && cur_dm;
  end
  // the bus is only ever driven by us during write halfwords, so reads always see a released bus
  assign data = wr ? (state == HI ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_dm  <= 1'b0;
      cur_dm   <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      addr     <= '0;
      hi_q     <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        cur_dm  <= pick_dm;
        last_dm <= pick_dm;
        we_q    <= pick_dm && dm_we;
        wdata_q <= dm_wdata;
        be_q    <= dm_be;
        addr    <= gaddr;
      end
      if (state == HI) begin
        addr <= addr | 18'd1;
        hi_q <= data;
      end
      if (state == LO && !we_q && cur_dm) dm_rdata <= {hi_q, data};
      if (state == LO && !we_q && !cur_dm) if_rdata <= {hi_q, data};
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows; polarity and synchronicity are fixed:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-002 The instruction-fetch port SHALL be:
- if_req  input  1  fetch request.
- if_addr  input  18  halfword address.
- if_rdata  output  32  fetched word.
- if_ack  output  1  one-cycle completion pulse.
REQ-003 The data port SHALL be:
- dm_req  input  1  data request.
- dm_we  input  1  1 = write, 0 = read.
- dm_addr  input  18  halfword address.
- dm_wdata  input  32  write word.
- dm_be  input  4  byte enables; bit 3 = bits 31:24.
- dm_rdata  output  32  read word.
- dm_ack  output  1  one-cycle completion pulse.
REQ-004 The SRAM port SHALL be:
- addr  output  18  SRAM halfword address.
- data  inout  16  SRAM data bus.
- wre, oute, chip_en, hb_mask, lb_mask  output  1 each  SRAM write enable, output enable, chip enable, upper-byte mask and lower-byte mask; all active-low.

Function
REQ-005 A 32-bit word at address A SHALL be big-endian: bits 31:16 at halfword A and bits 15:0 at A+1, with A = {addr[17:1],1'b0} (address bit 0 ignored).
REQ-006 The FSM SHALL have states IDLE, HI, LO and ACK.
- IDLE to HI on grant.
- HI to LO and LO to ACK unconditionally.
- ACK to HI on a new grant, otherwise to IDLE.
REQ-007 Each grant SHALL latch the port, dm_we, the address, dm_wdata and dm_be; later input changes SHALL NOT affect the transaction in progress.
REQ-008 Arbitration SHALL be round-robin between the two ports.
- A single pending request is granted directly.
- With both pending, the port not granted last wins.
- After reset, the data port wins the first tie.
REQ-009 A read in HI/LO SHALL drive: chip_en=0, oute=0, wre=1, hb_mask=0, lb_mask=0, addr=A / A+1, data=Z. The SRAM word SHALL be captured at the rising edge ending HI (bits 31:16) and LO (bits 15:0).
REQ-010 A write in HI/LO SHALL drive: chip_en=0, oute=1, wre=0, addr=A / A+1.
- HI drives data=wdata[31:16], hb_mask=~be[3], lb_mask=~be[2].
- LO drives data=wdata[15:0], hb_mask=~be[1], lb_mask=~be[0].
- dm_be=0000 still runs both cycles, with all masks high.
REQ-011 In ACK, the granted port's ack SHALL be 1 for exactly one cycle and its rdata SHALL be valid. rdata SHALL hold until that port's next ack; a write ack SHALL leave dm_rdata unchanged.
REQ-012 Latency SHALL be 3 cycles from the grant edge to the ack cycle. Back-to-back transactions SHALL sustain one word per 3 cycles.
REQ-013 A requester holding req high in its own ack cycle SHALL be treated as issuing a new request, subject to arbitration.
REQ-014 Dropping req before ack SHALL NOT abort a transaction; it completes and acks.
REQ-015 In IDLE and ACK the SRAM outputs SHALL be: chip_en=1, oute=1, wre=1, hb_mask=1, lb_mask=1, addr held, data=Z.
REQ-016 data SHALL be driven only in write HI/LO states, so bus turnaround always passes through Z.

Reset
REQ-017 On reset=0, regardless of state:
- FSM goes to IDLE.
- if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, addr=0.
- chip_en, oute, wre, hb_mask and lb_mask go to 1; data goes to Z.
- The round-robin pointer favours the data port.
REQ-018 A transaction interrupted by reset SHALL be discarded; no ack SHALL follow reset release.

Verification
REQ-019 Read: mem[32]=0x0122, mem[33]=0x4820; pulse if_req with if_addr=33 -> addr 32 then 33, if_ack in cycle 3, if_rdata=0x01224820.
REQ-020 Write: dm_we=1, dm_addr=40, dm_wdata=0xDEADBEEF, dm_be=1111 -> mem[40]=0xDEAD, mem[41]=0xBEEF, dm_ack in cycle 3, wre low exactly 2 cycles.
REQ-021 Byte write: mem[41]=0x0000; dm_be=0010, dm_wdata=0x000055AA at addr 40 -> mem[41]=0x5500, mem[40] unchanged.
REQ-022 Contention: if_req and dm_req held high from reset release -> grants alternate D, I, D, I, with acks 3 cycles apart.
REQ-023 Reset mid-write: reset=0 during HI -> SRAM controls go high and data goes Z within the same cycle, mem[41] is untouched, and no ack follows.
REQ-024 Sample Fibonacci image: run until the program's halt address is fetched -> register 2 holds the expected sum. A bus monitor SHALL flag any overlap of wre=0 with oute=0, and any data drive while oute=0.
